// File: rtl/dec_alu_pkg.sv
// Shared constants for the decode-to-ALU skid stage: field widths, packed-beat
// layout (fields packed from bit 0 upward in listed order) and state encoding.
package dec_alu_pkg;

  localparam int OPCODE_W   = 7;
  localparam int ALUCTL_W   = 4;
  localparam int DCCTL_W    = 3;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam int OFF_OPCODE  = 0;
  localparam int OFF_WB_WE   = OFF_OPCODE + OPCODE_W;
  localparam int OFF_DCCTL   = OFF_WB_WE + 1;
  localparam int OFF_WB_ADDR = OFF_DCCTL + DCCTL_W;

  // Offsets past wb_addr depend on the data/address widths of the instance.
  function automatic int off_rs1_data(input int aw);
    return OFF_WB_ADDR + aw;
  endfunction

  function automatic int off_rs2_data(input int dw, input int aw);
    return off_rs1_data(aw) + dw;
  endfunction

  function automatic int off_alu_op(input int dw, input int aw);
    return off_rs2_data(dw, aw) + dw;
  endfunction

  function automatic int off_imm(input int dw, input int aw);
    return off_alu_op(dw, aw) + ALUCTL_W;
  endfunction

  function automatic int off_rs1_addr(input int dw, input int aw);
    return off_imm(dw, aw) + dw;
  endfunction

  function automatic int off_rs2_addr(input int dw, input int aw);
    return off_rs1_addr(dw, aw) + aw;
  endfunction

  function automatic int payload_w(input int dw, input int aw);
    return off_rs2_addr(dw, aw) + aw;
  endfunction

  localparam int PAYLOAD_W = payload_w(DEF_DATA_W, DEF_ADDR_W);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/dec_alu_pipe_slot.sv
// One storage slot: a valid flag plus a payload register. Clear wins over load
// and blocks the payload write, so a squashed slot keeps its old contents.
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_ld,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic         o_vld,
  output logic [W-1:0] o_q
);

  logic         r_vld;
  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_vld <= 1'b0;
    else if (i_clr) r_vld <= 1'b0;
    else if (i_ld)  r_vld <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_q <= '0;
    else if (i_ld && !i_clr) r_q <= i_d;
  end

  assign o_vld = r_vld;
  assign o_q   = r_q;

endmodule

// File: rtl/dec_alu_pipe.sv
// Decode-to-ALU pipeline register with a skid slot so in_ready is fully
// registered, plus a saturating back-pressure counter.
module dec_alu_pipe
  import dec_alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   flush,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [payload_w(DATA_W, ADDR_W)-1:0]   in_payload,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [payload_w(DATA_W, ADDR_W)-1:0]   out_payload,
  input  logic                                   stat_clr,
  output logic [CNT_W-1:0]                       stall_cnt
);

  localparam int PW = payload_w(DATA_W, ADDR_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic          w_main_vld, w_skid_vld;
  logic [PW-1:0] w_main_q, w_skid_q, w_main_d;
  logic          w_main_ld, w_main_clr, w_skid_ld, w_skid_clr;
  logic          w_accept, w_xfer;
  state_e        w_state;
  logic [CNT_W-1:0] r_stall_cnt;

  assign in_ready  = reset & ~w_skid_vld;
  assign out_valid = w_main_vld;
  assign w_accept  = in_valid & in_ready;
  assign w_xfer    = w_main_vld & out_ready;

  // The two slot valid bits are the state register; decode them here.
  always_comb begin
    w_state = ST_FULL;
    case ({w_skid_vld, w_main_vld})
      2'b00:   w_state = ST_EMPTY;
      2'b01:   w_state = ST_ONE;
      default: w_state = ST_FULL;
    endcase
  end

  always_comb begin
    w_main_ld  = 1'b0;
    w_main_clr = 1'b0;
    w_skid_ld  = 1'b0;
    w_skid_clr = 1'b0;
    w_main_d   = in_payload;
    case (w_state)
      ST_EMPTY: w_main_ld = w_accept;
      ST_ONE: begin
        w_main_ld  = w_accept & w_xfer;
        w_main_clr = w_xfer & ~w_accept;
        w_skid_ld  = w_accept & ~w_xfer;
      end
      default: begin
        w_main_d   = w_skid_q;
        w_main_ld  = w_xfer;
        w_skid_clr = w_xfer;
      end
    endcase
    if (flush) begin
      w_main_ld  = 1'b0;
      w_skid_ld  = 1'b0;
      w_main_clr = 1'b1;
      w_skid_clr = 1'b1;
    end
  end

  pipe_slot #(.W(PW)) u_main (
    .clk   (clk),
    .rst_n (reset),
    .i_ld  (w_main_ld),
    .i_clr (w_main_clr),
    .i_d   (w_main_d),
    .o_vld (w_main_vld),
    .o_q   (w_main_q)
  );

  pipe_slot #(.W(PW)) u_skid (
    .clk   (clk),
    .rst_n (reset),
    .i_ld  (w_skid_ld),
    .i_clr (w_skid_clr),
    .i_d   (in_payload),
    .o_vld (w_skid_vld),
    .o_q   (w_skid_q)
  );

  // Side-effecting fields are forced to a bubble when nothing is presented.
  always_comb begin
    out_payload = w_main_q;
    if (!w_main_vld) begin
      out_payload[OFF_WB_WE]             = 1'b0;
      out_payload[OFF_DCCTL +: DCCTL_W]  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_stall_cnt <= '0;
    else if (stat_clr)
      r_stall_cnt <= '0;
    else if (w_main_vld && !out_ready && r_stall_cnt != CNT_MAX)
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_dec_alu_pipe.sv
// Scoreboard bench for dec_alu_pipe: accepted beats are queued and matched
// against transfers; occupancy, in_ready and the stall counter are modelled.
module tb_dec_alu_pipe;
  import dec_alu_pkg::*;

  localparam int DW      = 32;
  localparam int AW      = 5;
  localparam int CW      = 4;
  localparam int PW      = payload_w(DW, AW);
  localparam int IMM_OFF = off_imm(DW, AW);

  logic          clk, reset, flush, in_valid, in_ready, out_valid, out_ready, stat_clr;
  logic [PW-1:0] in_payload, out_payload;
  logic [CW-1:0] stall_cnt;

  dec_alu_pipe #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_payload  (in_payload),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload (out_payload),
    .stat_clr    (stat_clr),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_chk = 0;
  int            n_bad = 0;
  logic [PW-1:0] sb[$];
  logic [CW-1:0] m_cnt = '0;
  bit            mon_en = 1'b0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] mk(input logic [31:0] imm);
    logic [127:0]  t;
    logic [PW-1:0] p;
    t = {$urandom, $urandom, $urandom, $urandom};
    p = t[PW-1:0];
    p[OFF_WB_WE]            = 1'b1;
    p[OFF_DCCTL +: DCCTL_W] = 3'd5;
    p[IMM_OFF +: 32]        = imm;
    return p;
  endfunction

  // Negedge monitor: inputs are stable, so this cycle's handshakes are known.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [PW-1:0] e;
      chk("out_valid", out_valid, sb.size() > 0);
      chk("in_ready", in_ready, sb.size() < 2);
      chk("stall_cnt", stall_cnt, m_cnt);
      if (!out_valid)
        chk("bubble", {out_payload[OFF_WB_WE], out_payload[OFF_DCCTL +: DCCTL_W]}, 0);
      if (out_valid && out_ready) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("data", out_payload, e);
        end else
          chk("spurious_beat", 1, 0);
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(in_payload);
      if (stat_clr) m_cnt = '0;
      else if (out_valid && !out_ready && m_cnt != '1) m_cnt = m_cnt + 1'b1;
    end
  end

  task automatic offer(input logic [PW-1:0] p);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_payload = p;
    for (int g = 0; g < 50 && !done; g++) begin
      done = in_ready;
      step();
    end
    if (!done) chk("offer_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int g = 0; g < 20 && sb.size() != 0; g++) step();
    step();
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic clr_stats();
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; stat_clr = 1'b0;
    in_payload = '0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_payload", out_payload, 0);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("rel_in_ready", in_ready, 1);
    mon_en = 1'b1;

    // Steady flow: one beat per cycle, 1-cycle latency.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_payload = mk(i);
      chk("steady_rdy", in_ready, 1);
      step();
      chk("steady_vld", out_valid, 1);
      chk("steady_imm", out_payload[IMM_OFF +: 32], i);
    end
    in_valid = 1'b0;
    drain();
    chk("steady_stall", stall_cnt, 0);

    // Back-pressure: A, B fill both slots, C waits.
    clr_stats();
    out_ready = 1'b0;
    offer(mk(32'hA));
    offer(mk(32'hB));
    in_valid = 1'b1;
    in_payload = mk(32'hC);
    repeat (3) step();
    chk("bp_in_ready", in_ready, 0);
    chk("bp_stall", stall_cnt, 4);
    out_ready = 1'b1;
    for (int g = 0; g < 10; g++) begin
      if (in_ready) begin
        step();
        break;
      end
      step();
    end
    in_valid = 1'b0;
    drain();

    // Flush in FULL with a simultaneous offer.
    out_ready = 1'b0;
    offer(mk(32'h11));
    offer(mk(32'h12));
    in_valid = 1'b1;
    in_payload = mk(32'h13);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    chk("fl_wb_we", out_payload[OFF_WB_WE], 0);
    chk("fl_dcctl", out_payload[OFF_DCCTL +: DCCTL_W], 0);
    out_ready = 1'b1;
    repeat (4) step();
    chk("fl_no_late", out_valid, 0);

    // Flush while a transfer completes: X delivered, Y dropped.
    offer(mk(32'h21));
    in_valid = 1'b1;
    in_payload = mk(32'h22);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    repeat (3) step();
    chk("flx_empty", out_valid, 0);

    // Asynchronous reset in FULL with stall_cnt at 5.
    clr_stats();
    out_ready = 1'b0;
    offer(mk(32'h31));
    offer(mk(32'h32));
    for (int g = 0; g < 20 && m_cnt != 5; g++) step();
    chk("pre_rst_stall", stall_cnt, 5);
    chk("pre_rst_full", in_ready, 0);
    mon_en = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_stall", stall_cnt, 0);
    chk("arst_payload", out_payload, 0);
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    m_cnt = '0;
    step();
    chk("arst_rel_rdy", in_ready, 1);
    chk("arst_rel_vld", out_valid, 0);
    mon_en = 1'b1;

    // Saturation, then clear with priority over a stall.
    out_ready = 1'b0;
    offer(mk(32'h41));
    repeat (20) step();
    chk("sat_stall", stall_cnt, 15);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("clr_stall", stall_cnt, 0);
    drain();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
